pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/next_pc_sel.sv | 41 ++++
 rtl/pc_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-side constants and PC FSM state type (trap state exists only with PC_MISALIGN_TRAP_EN)
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        TRAP = 2'd3
    } pc_state_e;
`else
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;
`endif

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC priority mux (jump > branch > pc+4); macro PC_MISALIGN_TRAP_EN
module next_pc_sel
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc_plus4,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
`ifdef PC_MISALIGN_TRAP_EN
    output logic            misaligned,
`endif
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] target;
    logic            target_sel;

    // Pick the redirect source; jump outranks branch, sequential is the fallback
    always_comb begin
        target     = pc_plus4;
        target_sel = 1'b0;
        if (jump_en) begin
            target     = jump_target;
            target_sel = 1'b1;
        end else if (branch_taken) begin
            target     = branch_target;
            target_sel = 1'b1;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Misaligned redirects are passed through untouched; the FSM turns them into a trap
    assign misaligned = target_sel && (target[1:0] != 2'b00);
    assign next_pc    = target;
`else
    // Without trapping, redirect targets are silently word-aligned
    assign next_pc = target_sel ? {target[XLEN-1:2], 2'b00} : target;
`endif

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register and fetch-handshake FSM; macro PC_MISALIGN_TRAP_EN
module pc_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            misalign_err
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            misalign_err_q, misalign_err_d;
    logic [XLEN-1:0] next_pc;
    logic            advance;
`ifdef PC_MISALIGN_TRAP_EN
    logic            misaligned;
`else
    logic            unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
`endif

    assign pc_plus4 = pc_q + PC_STEP;
    assign advance  = fetch_valid_q && fetch_ready && !stall;

    next_pc_sel u_next_pc_sel (
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
`ifdef PC_MISALIGN_TRAP_EN
        .misaligned    (misaligned),
`endif
        .next_pc       (next_pc)
    );

    // Next-state logic: redirect inputs only matter on an advance cycle, otherwise the PC holds
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        fetch_valid_d  = fetch_valid_q;
        misalign_err_d = 1'b0;
        case (state_q)
            BOOT: begin
                state_d       = RUN;
                fetch_valid_d = 1'b1;
            end
            RUN, HOLD: begin
                fetch_valid_d = 1'b1;
                if (advance) begin
                    pc_d    = next_pc;
                    state_d = RUN;
`ifdef PC_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        pc_d           = TRAP_VECTOR;
                        state_d        = TRAP;
                        fetch_valid_d  = 1'b0;
                        misalign_err_d = 1'b1;
                    end
`endif
                end else begin
                    state_d = HOLD;
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            TRAP: begin
                state_d       = RUN;
                fetch_valid_d = 1'b1;
            end
`endif
            default: begin
                state_d       = BOOT;
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset forces the boot vector immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BOOT;
            pc_q           <= RESET_VECTOR;
            fetch_valid_q  <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_valid_q  <= fetch_valid_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_err = misalign_err_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule
